// File: rtl/cpu_pkg.sv
// Shared opcodes, ALU op codes, sequencer states and instruction classes for the hard-wired control unit.
package cpu_pkg;

  localparam int OPC_W = 5;
  localparam int IR_W  = 32;

  localparam logic [OPC_W-1:0] OP_ADD  = 5'b00000;
  localparam logic [OPC_W-1:0] OP_SUB  = 5'b00001;
  localparam logic [OPC_W-1:0] OP_AND  = 5'b00010;
  localparam logic [OPC_W-1:0] OP_OR   = 5'b00011;
  localparam logic [OPC_W-1:0] OP_ADDI = 5'b01011;
  localparam logic [OPC_W-1:0] OP_ANDI = 5'b01100;
  localparam logic [OPC_W-1:0] OP_ORI  = 5'b01101;
  localparam logic [OPC_W-1:0] OP_MUL  = 5'b01111;
  localparam logic [OPC_W-1:0] OP_DIV  = 5'b10000;
  localparam logic [OPC_W-1:0] OP_LD   = 5'b10010;
  localparam logic [OPC_W-1:0] OP_NOP  = 5'b11010;
  localparam logic [OPC_W-1:0] OP_HALT = 5'b11011;

  // ALU select values share the R-type opcode encoding
  localparam logic [OPC_W-1:0] ALU_ADD = OP_ADD;
  localparam logic [OPC_W-1:0] ALU_SUB = OP_SUB;
  localparam logic [OPC_W-1:0] ALU_AND = OP_AND;
  localparam logic [OPC_W-1:0] ALU_OR  = OP_OR;
  localparam logic [OPC_W-1:0] ALU_MUL = OP_MUL;
  localparam logic [OPC_W-1:0] ALU_DIV = OP_DIV;

  typedef enum logic [3:0] {
    S_RESET, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
  } state_t;

  typedef enum logic [2:0] {
    C_RTYPE, C_IMM, C_LD, C_MULDIV, C_NOP, C_HALT, C_ILL
  } iclass_t;

  function automatic logic [OPC_W-1:0] ir_opcode(input logic [IR_W-1:0] ir);
    return ir[IR_W-1 -: OPC_W];
  endfunction

endpackage

// File: rtl/control_decode.sv
// Combinational opcode decode: instruction class plus the ALU op used in T4.
// CTRL_MULDIV_EN makes MUL/DIV legal; otherwise they fall into the illegal class.
module control_decode
  import cpu_pkg::*;
(
  input  logic [OPC_W-1:0] i_opcode,
  output iclass_t          o_class,
  output logic [OPC_W-1:0] o_alu_op
);

  always_comb begin
    o_class  = C_ILL;
    o_alu_op = ALU_ADD;
    case (i_opcode)
      OP_ADD, OP_SUB, OP_AND, OP_OR: begin
        o_class  = C_RTYPE;
        o_alu_op = i_opcode;
      end
      OP_ADDI: begin o_class = C_IMM; o_alu_op = ALU_ADD; end
      OP_ANDI: begin o_class = C_IMM; o_alu_op = ALU_AND; end
      OP_ORI:  begin o_class = C_IMM; o_alu_op = ALU_OR;  end
      OP_LD:   begin o_class = C_LD;  o_alu_op = ALU_ADD; end
      OP_NOP:  o_class = C_NOP;
      OP_HALT: o_class = C_HALT;
`ifdef CTRL_MULDIV_EN
      OP_MUL:  begin o_class = C_MULDIV; o_alu_op = ALU_MUL; end
      OP_DIV:  begin o_class = C_MULDIV; o_alu_op = ALU_DIV; end
`endif
      default: o_class = C_ILL;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Hard-wired fetch/decode/execute sequencer producing Moore strobes for the Datapath.
// CTRL_MULDIV_EN adds the MUL/DIV sequences and the ZHI/HI/LO strobe ports.
module control_unit
  import cpu_pkg::*;
(
  input  logic             i_Clock,
  input  logic             i_Clear,
  input  logic [IR_W-1:0]  i_IR,
  input  logic             i_Stop,
  output logic             o_Run,
  output logic             o_Illegal,
  output logic [OPC_W-1:0] o_CONTROL,
  output logic             o_IncPC,
  output logic             o_Read,
  output logic             o_PC_Out,
  output logic             o_MDR_Out,
  output logic             o_ZLO_Out,
  output logic             o_C_Out,
  output logic             o_R_Out,
  output logic             o_BA_Out,
  output logic             o_PC_In,
  output logic             o_MDR_In,
  output logic             o_MAR_In,
  output logic             o_IR_In,
  output logic             o_Y_In,
  output logic             o_ZLO_In,
  output logic             o_R_In,
  output logic             o_G_RA,
  output logic             o_G_RB,
`ifdef CTRL_MULDIV_EN
  output logic             o_G_RC,
  output logic             o_ZHI_In,
  output logic             o_ZHI_Out,
  output logic             o_HI_In,
  output logic             o_LO_In
`else
  output logic             o_G_RC
`endif
);

  state_t           r_state;
  state_t           w_next;
  iclass_t          w_class;
  logic [OPC_W-1:0] w_alu_op;
  logic             w_last;
  logic             w_unused_ir;

  assign w_unused_ir = ^i_IR[IR_W-OPC_W-1:0];

  control_decode u_decode (
    .i_opcode (ir_opcode(i_IR)),
    .o_class  (w_class),
    .o_alu_op (w_alu_op)
  );

  always_ff @(posedge i_Clock) begin
    if (i_Clear) r_state <= S_RESET;
    else         r_state <= w_next;
  end

  // w_last marks an instruction's final state, where Stop is sampled
  always_comb begin
    w_next = r_state;
    w_last = 1'b0;
    case (r_state)
      S_RESET: w_next = S_T0;
      S_T0:    w_next = S_T1;
      S_T1:    w_next = S_T2;
      S_T2:    w_next = S_T3;
      S_T3: begin
        if (w_class inside {C_RTYPE, C_IMM, C_LD, C_MULDIV}) w_next = S_T4;
        else if (w_class == C_HALT)                         w_next = S_HALT;
        else                                                w_last = 1'b1;
      end
      S_T4:    w_next = S_T5;
      S_T5: begin
        if (w_class inside {C_LD, C_MULDIV}) w_next = S_T6;
        else                                 w_last = 1'b1;
      end
      S_T6: begin
        if (w_class == C_LD) w_next = S_T7;
        else                 w_last = 1'b1;
      end
      S_T7:    w_last = 1'b1;
      S_HALT:  w_next = S_HALT;
      default: w_next = S_RESET;
    endcase
    if (w_last) w_next = i_Stop ? S_HALT : S_T0;
  end

  always_comb begin
    o_Run     = (r_state != S_RESET) && (r_state != S_HALT);
    o_Illegal = 1'b0;
    o_CONTROL = '0;
    o_IncPC   = 1'b0; o_Read   = 1'b0; o_PC_Out = 1'b0; o_MDR_Out = 1'b0;
    o_ZLO_Out = 1'b0; o_C_Out  = 1'b0; o_R_Out  = 1'b0; o_BA_Out  = 1'b0;
    o_PC_In   = 1'b0; o_MDR_In = 1'b0; o_MAR_In = 1'b0; o_IR_In   = 1'b0;
    o_Y_In    = 1'b0; o_ZLO_In = 1'b0; o_R_In   = 1'b0;
    o_G_RA    = 1'b0; o_G_RB   = 1'b0; o_G_RC   = 1'b0;
`ifdef CTRL_MULDIV_EN
    o_ZHI_In  = 1'b0; o_ZHI_Out = 1'b0; o_HI_In = 1'b0; o_LO_In = 1'b0;
`endif
    case (r_state)
      S_T0: begin o_PC_Out = 1'b1; o_MAR_In = 1'b1; o_IncPC = 1'b1; end
      S_T1: begin o_Read = 1'b1; o_MDR_In = 1'b1; end
      S_T2: begin o_MDR_Out = 1'b1; o_IR_In = 1'b1; end
      S_T3: begin
        if (w_class inside {C_RTYPE, C_MULDIV}) begin
          o_G_RB = 1'b1; o_R_Out = 1'b1; o_Y_In = 1'b1;
        end else if (w_class inside {C_IMM, C_LD}) begin
          o_G_RB = 1'b1; o_BA_Out = 1'b1; o_Y_In = 1'b1;
        end else if (w_class == C_ILL) begin
          o_Illegal = 1'b1;
        end
      end
      S_T4: begin
        if (w_class inside {C_RTYPE, C_MULDIV}) begin
          o_G_RC = 1'b1; o_R_Out = 1'b1; o_ZLO_In = 1'b1; o_CONTROL = w_alu_op;
`ifdef CTRL_MULDIV_EN
          o_ZHI_In = (w_class == C_MULDIV);
`endif
        end else if (w_class inside {C_IMM, C_LD}) begin
          o_C_Out = 1'b1; o_ZLO_In = 1'b1; o_CONTROL = w_alu_op;
        end
      end
      S_T5: begin
        if (w_class inside {C_RTYPE, C_IMM}) begin
          o_ZLO_Out = 1'b1; o_G_RA = 1'b1; o_R_In = 1'b1;
        end else if (w_class == C_LD) begin
          o_ZLO_Out = 1'b1; o_MAR_In = 1'b1;
        end
`ifdef CTRL_MULDIV_EN
        else if (w_class == C_MULDIV) begin
          o_ZLO_Out = 1'b1; o_LO_In = 1'b1;
        end
`endif
      end
      S_T6: begin
        if (w_class == C_LD) begin
          o_Read = 1'b1; o_MDR_In = 1'b1;
        end
`ifdef CTRL_MULDIV_EN
        else if (w_class == C_MULDIV) begin
          o_ZHI_Out = 1'b1; o_HI_In = 1'b1;
        end
`endif
      end
      S_T7: begin
        if (w_class == C_LD) begin
          o_MDR_Out = 1'b1; o_G_RA = 1'b1; o_R_In = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// Random instruction stream against a per-opcode strobe table; checks every cycle incl. Stop and Clear aborts.
module tb_control_unit;

  logic        i_Clock = 1'b0;
  logic        i_Clear, i_Stop;
  logic [31:0] i_IR;
  logic        o_Run, o_Illegal;
  logic [4:0]  o_CONTROL;
  logic o_IncPC, o_Read, o_PC_Out, o_MDR_Out, o_ZLO_Out, o_C_Out, o_R_Out, o_BA_Out;
  logic o_PC_In, o_MDR_In, o_MAR_In, o_IR_In, o_Y_In, o_ZLO_In, o_R_In, o_G_RA, o_G_RB, o_G_RC;
  logic o_ZHI_In, o_ZHI_Out, o_HI_In, o_LO_In;

  always #5 i_Clock = ~i_Clock;

  control_unit dut (
    .i_Clock(i_Clock), .i_Clear(i_Clear), .i_IR(i_IR), .i_Stop(i_Stop),
    .o_Run(o_Run), .o_Illegal(o_Illegal), .o_CONTROL(o_CONTROL),
    .o_IncPC(o_IncPC), .o_Read(o_Read), .o_PC_Out(o_PC_Out), .o_MDR_Out(o_MDR_Out),
    .o_ZLO_Out(o_ZLO_Out), .o_C_Out(o_C_Out), .o_R_Out(o_R_Out), .o_BA_Out(o_BA_Out),
    .o_PC_In(o_PC_In), .o_MDR_In(o_MDR_In), .o_MAR_In(o_MAR_In), .o_IR_In(o_IR_In),
    .o_Y_In(o_Y_In), .o_ZLO_In(o_ZLO_In), .o_R_In(o_R_In),
    .o_G_RA(o_G_RA), .o_G_RB(o_G_RB),
`ifdef CTRL_MULDIV_EN
    .o_G_RC(o_G_RC),
    .o_ZHI_In(o_ZHI_In), .o_ZHI_Out(o_ZHI_Out), .o_HI_In(o_HI_In), .o_LO_In(o_LO_In)
`else
    .o_G_RC(o_G_RC)
`endif
  );

`ifndef CTRL_MULDIV_EN
  assign {o_ZHI_In, o_ZHI_Out, o_HI_In, o_LO_In} = 4'b0;
`endif

  // one bit per strobe; CONTROL in [28:24]
  localparam logic [31:0] INCPC = 32'h1 << 0,  READ   = 32'h1 << 1,  PC_OUT = 32'h1 << 2;
  localparam logic [31:0] MDR_OUT = 32'h1 << 3, ZLO_OUT = 32'h1 << 4, C_OUT = 32'h1 << 5;
  localparam logic [31:0] R_OUT = 32'h1 << 6,  BA_OUT = 32'h1 << 7,  PC_IN  = 32'h1 << 8;
  localparam logic [31:0] MDR_IN = 32'h1 << 9, MAR_IN = 32'h1 << 10, IR_IN  = 32'h1 << 11;
  localparam logic [31:0] Y_IN = 32'h1 << 12,  ZLO_IN = 32'h1 << 13, R_IN   = 32'h1 << 14;
  localparam logic [31:0] GRA = 32'h1 << 15,   GRB = 32'h1 << 16,    GRC    = 32'h1 << 17;
  localparam logic [31:0] ZHI_IN = 32'h1 << 18, ZHI_OUT = 32'h1 << 19, HI_IN = 32'h1 << 20;
  localparam logic [31:0] LO_IN = 32'h1 << 21, ILL = 32'h1 << 29,    RUN    = 32'h1 << 30;
  localparam logic [31:0] BUSMASK = PC_OUT | MDR_OUT | ZLO_OUT | C_OUT | R_OUT | BA_OUT | ZHI_OUT;
  localparam logic [31:0] T0VEC = RUN | PC_OUT | MAR_IN | INCPC;

`ifdef CTRL_MULDIV_EN
  localparam bit MULDIV = 1'b1;
`else
  localparam bit MULDIV = 1'b0;
`endif

  logic [31:0] obs;
  always_comb begin
    obs = '0;
    obs[0] = o_IncPC; obs[1] = o_Read; obs[2] = o_PC_Out; obs[3] = o_MDR_Out;
    obs[4] = o_ZLO_Out; obs[5] = o_C_Out; obs[6] = o_R_Out; obs[7] = o_BA_Out;
    obs[8] = o_PC_In; obs[9] = o_MDR_In; obs[10] = o_MAR_In; obs[11] = o_IR_In;
    obs[12] = o_Y_In; obs[13] = o_ZLO_In; obs[14] = o_R_In; obs[15] = o_G_RA;
    obs[16] = o_G_RB; obs[17] = o_G_RC; obs[18] = o_ZHI_In; obs[19] = o_ZHI_Out;
    obs[20] = o_HI_In; obs[21] = o_LO_In; obs[28:24] = o_CONTROL;
    obs[29] = o_Illegal; obs[30] = o_Run;
  end

  int n_chk = 0, n_fail = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  task automatic chk_cycle(input string tag, input logic [31:0] exp);
    chk(tag, obs, exp);
    chk({tag, "_bus"}, {31'b0, $countones(obs & BUSMASK) <= 1}, 32'h1);
  endtask

  function automatic logic [31:0] ctl(input logic [4:0] op);
    return {3'b0, op, 24'b0};
  endfunction

  // expected per-state outputs for a whole instruction, T0 first
  task automatic build(input logic [4:0] op);
    logic [31:0] s[$];
    s = '{PC_OUT | MAR_IN | INCPC, READ | MDR_IN, MDR_OUT | IR_IN};
    case (op)
      5'b00000, 5'b00001, 5'b00010, 5'b00011:
        s = {s, GRB | R_OUT | Y_IN, GRC | R_OUT | ctl(op) | ZLO_IN, ZLO_OUT | GRA | R_IN};
      5'b01011: s = {s, GRB | BA_OUT | Y_IN, C_OUT | ZLO_IN | ctl(5'd0), ZLO_OUT | GRA | R_IN};
      5'b01100: s = {s, GRB | BA_OUT | Y_IN, C_OUT | ZLO_IN | ctl(5'd2), ZLO_OUT | GRA | R_IN};
      5'b01101: s = {s, GRB | BA_OUT | Y_IN, C_OUT | ZLO_IN | ctl(5'd3), ZLO_OUT | GRA | R_IN};
      5'b10010: s = {s, GRB | BA_OUT | Y_IN, C_OUT | ZLO_IN | ctl(5'd0), ZLO_OUT | MAR_IN,
                     READ | MDR_IN, MDR_OUT | GRA | R_IN};
      5'b11010, 5'b11011: s = {s, 32'h0};
      5'b01111, 5'b10000:
        if (MULDIV) s = {s, GRB | R_OUT | Y_IN, GRC | R_OUT | ctl(op) | ZLO_IN | ZHI_IN,
                         ZLO_OUT | LO_IN, ZHI_OUT | HI_IN};
        else s = {s, ILL};
      default: s = {s, ILL};
    endcase
    exp_q.delete();
    foreach (s[i]) exp_q.push_back(s[i] | RUN);
  endtask

  // precondition: DUT sits in T0 (already checked). stop_mode 0 none, 1 random, 2 from T4 on
  task automatic run_instr(input logic [31:0] ir, input int abort_at, input int stop_mode);
    int n;
    logic [4:0] op;
    op = ir[31:27];
    i_IR = ir;
    build(op);
    n = exp_q.size();
    for (int i = 1; i <= n; i++) begin
      i_Stop = (stop_mode == 1) ? 1'($urandom_range(1)) : (stop_mode == 2) ? (i - 1 >= 4) : 1'b0;
      i_Clear = (i - 1 == abort_at);
      @(posedge i_Clock); #1;
      if (i_Clear) begin
        i_Clear = 1'b0;
        chk_cycle($sformatf("op%02h_abort%0d", op, abort_at), 32'h0);
        @(posedge i_Clock); #1;
        chk_cycle("restart_t0", T0VEC);
        return;
      end
      if (i < n) chk_cycle($sformatf("op%02h_s%0d", op, i), exp_q[i]);
    end
    if (op == 5'b11011 || i_Stop) begin
      chk_cycle($sformatf("op%02h_halt", op), 32'h0);
      repeat (2) begin
        i_Stop = 1'($urandom_range(1));
        @(posedge i_Clock); #1;
        chk_cycle("halt_hold", 32'h0);
      end
      i_Clear = 1'b1;
      @(posedge i_Clock); #1;
      chk_cycle("halt_clear", 32'h0);
      i_Clear = 1'b0;
      @(posedge i_Clock); #1;
      chk_cycle("halt_restart", T0VEC);
    end else begin
      chk_cycle($sformatf("op%02h_next_t0", op), T0VEC);
    end
    i_Stop = 1'b0;
  endtask

  logic [4:0] ops [12] = '{5'b00000, 5'b00001, 5'b00010, 5'b00011, 5'b01011, 5'b01100,
                           5'b01101, 5'b01111, 5'b10000, 5'b10010, 5'b11010, 5'b11011};

  initial begin
    i_Clear = 1'b1; i_Stop = 1'b0; i_IR = 32'h0;
    @(posedge i_Clock); #1 chk_cycle("reset1", 32'h0);
    i_Stop = 1'b1;
    @(posedge i_Clock); #1 chk_cycle("reset2", 32'h0);
    i_Clear = 1'b0; i_Stop = 1'b0;
    @(posedge i_Clock); #1 chk_cycle("reset_t0", T0VEC);

    run_instr(32'h59087FFB, -1, 0);
    run_instr({5'b10010, 27'h0456789}, -1, 0);
    run_instr({5'b11111, 27'h7FFFFFF}, -1, 0);
    run_instr({5'b00000, 27'h0123456}, -1, 2);
    run_instr({5'b10010, 27'h0000001}, 6, 0);
    run_instr({5'b01111, 27'h0ABCDEF}, -1, 0);
    run_instr({5'b10000, 27'h0ABCDEF}, -1, 0);
    run_instr({5'b11010, 27'h0}, -1, 2);

    for (int k = 0; k < 300; k++) begin
      logic [4:0]  op;
      logic [31:0] ir;
      int          ab;
      op = ($urandom_range(4) == 0) ? 5'($urandom) : ops[$urandom_range(11)];
      ir = {op, 27'($urandom)};
      build(op);
      ab = ($urandom_range(19) == 0) ? int'($urandom_range(exp_q.size() - 1)) : -1;
      run_instr(ir, ab, ($urandom_range(7) == 0) ? 1 : 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
